fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined processor.
- Holds the program counter and issues one instruction-memory request at a time over a valid/ready handshake.
- Presents the IF/ID payload: instruction, PC, and PC+4.
- if_pc_plus4 feeds data0 of the downstream next-PC 2:1 mux. That mux's output returns to this block as redirect_pc, together with the redirect strobe.

---
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request, skid buffer, IF/ID payload.
// Optional perf counters (fetch_count, discard_count) enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      fetch_count,
    output logic [31:0]      discard_count
`endif
);

    localparam logic [31:0]      Nop    = 32'h0000_0013;
    localparam logic [WIDTH-1:0] PcStep = WIDTH'(4);

    typedef enum logic [1:0] {StReq, StWait, StFull, StDrain} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [31:0]       if_instr_q, if_instr_d;
    logic [WIDTH-1:0]  if_pc_q, if_pc_d;
    logic [WIDTH-1:0]  if_pc_plus4_q, if_pc_plus4_d;
    logic [31:0]       buf_instr_q, buf_instr_d;
    logic [WIDTH-1:0]  buf_pc_q, buf_pc_d;

    logic slot_free;
    logic rsp_take;
    logic rsp_drop;
    logic unused_redirect_lsbs;

    assign slot_free            = !if_valid_q || !stall;
    assign rsp_take             = (state_q == StWait) && imem_rsp_valid && !redirect;
    assign rsp_drop             = imem_rsp_valid &&
                                  (((state_q == StWait) && redirect) || (state_q == StDrain));
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq: begin
                if (imem_req_ready) state_d = redirect ? StDrain : StWait;
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    state_d = (redirect || slot_free) ? StReq : StFull;
                end else if (redirect) begin
                    state_d = StDrain;
                end
            end
            StFull: begin
                if (redirect || !stall) state_d = StReq;
            end
            StDrain: begin
                // A redirect here only retargets pc; the old response must still be drained.
                if (imem_rsp_valid) state_d = StReq;
            end
            default: state_d = StReq;
        endcase
    end

    always_comb begin
        imem_req_valid = (state_q == StReq) && !reset;
        imem_req_addr  = pc_q;
    end

    always_comb begin
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus4_d = if_pc_plus4_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;

        if (if_valid_q && !stall) if_valid_d = 1'b0;

        if (redirect) begin
            pc_d       = {redirect_pc[WIDTH-1:2], 2'b00};
            if_valid_d = 1'b0;
        end else if (rsp_take) begin
            pc_d = pc_q + PcStep;
            if (slot_free) begin
                if_valid_d    = 1'b1;
                if_instr_d    = imem_rsp_data;
                if_pc_d       = pc_q;
                if_pc_plus4_d = pc_q + PcStep;
            end else begin
                buf_instr_d = imem_rsp_data;
                buf_pc_d    = pc_q;
            end
        end else if ((state_q == StFull) && !stall) begin
            if_valid_d    = 1'b1;
            if_instr_d    = buf_instr_q;
            if_pc_d       = buf_pc_q;
            if_pc_plus4_d = buf_pc_q + PcStep;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_instr_q    <= Nop;
            if_pc_q       <= '0;
            if_pc_plus4_q <= '0;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus4_q <= if_pc_plus4_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_instr    = if_instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_plus4_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] discard_cnt_q, discard_cnt_d;

    always_comb begin
        fetch_cnt_d   = fetch_cnt_q + (rsp_take ? 32'd1 : 32'd0);
        discard_cnt_d = discard_cnt_q + (rsp_drop ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            fetch_cnt_q   <= fetch_cnt_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign fetch_count   = fetch_cnt_q;
    assign discard_count = discard_cnt_q;
`else
    logic unused_rsp_drop;
    assign unused_rsp_drop = rsp_drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected IF/ID payloads, a monitor
// pops them on consumption. A second instance checks PC wrap at RESET_PC = 0xFFFF_FFFC.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] plus4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;

    logic        req_valid2;
    logic [31:0] addr2;
    logic        rsp_valid2 = 1'b0;
    logic [31:0] rsp_data2 = '0;
    logic        if_valid2;
    logic [31:0] if_instr2, if_pc2, if_pc_plus4_2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, discard_count, fetch_count2, discard_count2;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   lat = 1;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .discard_count  (discard_count)
`endif
    );

    fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (req_valid2),
        .imem_req_ready (1'b1),
        .imem_req_addr  (addr2),
        .imem_rsp_valid (rsp_valid2),
        .imem_rsp_data  (rsp_data2),
        .stall          (1'b0),
        .redirect       (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (if_valid2),
        .if_instr       (if_instr2),
        .if_pc          (if_pc2),
        .if_pc_plus4    (if_pc_plus4_2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count2),
        .discard_count  (discard_count2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] plus4);
        exp_t e;
        e.pc    = pc;
        e.instr = pc ^ K;
        e.plus4 = plus4;
        exp_q.push_back(e);
    endtask

    // Instruction memory: one outstanding request, data = addr ^ K, response lat cycles later.
    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                a = imem_req_addr;
                repeat (lat) @(posedge clk);
                #1;
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = a ^ K;
                @(posedge clk);
                #1;
                imem_rsp_valid = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (req_valid2) begin
                a = addr2;
                @(posedge clk);
                #1;
                rsp_valid2 = 1'b1;
                rsp_data2  = a ^ K;
                @(posedge clk);
                #1;
                rsp_valid2 = 1'b0;
            end
        end
    end

    // Monitor: a payload is consumed on any negedge-sampled if_valid && !stall.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && if_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_payload: got pc %h expected none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("payload_pc", if_pc, e.pc);
                    check("payload_instr", if_instr, e.instr);
                    check("payload_plus4", if_pc_plus4, e.plus4);
                end
            end else if (!reset && if_valid && stall && exp_q.size() > 0) begin
                check("stall_hold_pc", if_pc, exp_q[0].pc);
            end
        end
    end

    // Wrap instance: first fetch at 0xFFFF_FFFC, next address 0.
    initial begin
        bit found;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req_valid2) found = 1;
        end
        check("wrap_first_req_seen", 32'(found), 32'd1);
        check("wrap_first_addr", addr2, 32'hFFFF_FFFC);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (if_valid2) found = 1;
        end
        check("wrap_payload_seen", 32'(found), 32'd1);
        check("wrap_if_pc", if_pc2, 32'hFFFF_FFFC);
        check("wrap_if_plus4", if_pc_plus4_2, 32'h0000_0000);
        check("wrap_if_instr", if_instr2, 32'hFFFF_FFFC ^ K);
        check("wrap_next_req_valid", 32'(req_valid2), 32'd1);
        check("wrap_next_addr", addr2, 32'h0000_0000);
    end

    initial begin
        bit found;
        reset       = 1'b1;
        imem_req_ready = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'h0000_0013);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_plus4", if_pc_plus4, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Memory not ready: request held at RESET_PC.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("notready_req_valid", 32'(imem_req_valid), 32'd1);
            check("notready_addr", imem_req_addr, 32'h0000_0100);
        end
        push_exp(32'h100, 32'h104);
        push_exp(32'h104, 32'h108);
        push_exp(32'h108, 32'h10C);
        @(posedge clk);
        #1 imem_req_ready = 1'b1;

        // Stall while 0x104 is presented; 0x108 lands in the skid buffer.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (if_valid && if_pc == 32'h104) found = 1;
        end
        check("saw_0x104", 32'(found), 32'd1);
        stall = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full_no_req", 32'(imem_req_valid), 32'd0);
        check("full_hold_pc", if_pc, 32'h104);
        check("full_hold_valid", 32'(if_valid), 32'd1);
        @(posedge clk);
        #1;
        stall = 1'b0;
        lat   = 2;

        // Redirect while waiting on 0x10C, before its response.
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_addr == 32'h10C) found = 1;
        end
        check("req_0x10c_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        lat         = 1;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        check("drain_no_req", 32'(imem_req_valid), 32'd0);
        check("drain_if_valid", 32'(if_valid), 32'd0);
        push_exp(32'h200, 32'h204);
        push_exp(32'h204, 32'h208);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid) found = 1;
        end
        check("redirect_req_seen", 32'(found), 32'd1);
        check("redirect_addr", imem_req_addr, 32'h200);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_addr == 32'h204) found = 1;
        end
        check("req_0x204_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1 imem_req_ready = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained_1", exp_q.size(), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, 32'd5);
        check("discard_count", discard_count, 32'd1);
`endif

        // Reset one cycle into WAIT; the memory's late response falls inside reset.
        @(posedge clk);
        #1 imem_req_ready = 1'b1;
        @(negedge clk);
        check("pre_reset_req_valid", 32'(imem_req_valid), 32'd1);
        check("pre_reset_addr", imem_req_addr, 32'h208);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_if_valid", 32'(if_valid), 32'd0);
        check("midrst_if_instr", if_instr, 32'h0000_0013);
        check("midrst_if_pc", if_pc, 32'h0);
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("midrst_fetch_count", fetch_count, 32'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        push_exp(32'h100, 32'h104);
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (imem_req_valid) found = 1;
        end
        check("restart_req_seen", 32'(found), 32'd1);
        check("restart_addr", imem_req_addr, 32'h100);
        @(posedge clk);
        #1 imem_req_ready = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained_2", exp_q.size(), 32'd0);
        repeat (3) @(negedge clk);
        check("idle_if_valid", 32'(if_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
